// File: rtl/eviction_write_buffer_pkg.sv
// rtl/eviction_write_buffer_pkg.sv - shared widths and FSM state type for the victim buffer
// Purpose: line/address/word types used by the buffer, its control FSM and the bus interface.
// Ports: none (package).
package eviction_write_buffer_pkg;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_wb_adr;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } wb_state;

  // Line address -> 16-bit byte address of the first byte in the line.
  function automatic lc3b_word line_byte_adr(lc3b_wb_adr adr);
    return {adr, 4'b0000};
  endfunction

endpackage

// File: rtl/eviction_write_buffer_if.sv
// rtl/eviction_write_buffer_if.sv - cache-side and memory-side bus of the victim buffer
// Purpose: bundles the cache eviction/fill handshake and the physical memory port.
// Ports: slave = buffer view (consumes wb_* requests, drives pmem_* strobes);
//        master = environment view (cache and memory model).
interface eviction_write_buffer_if;
  import eviction_write_buffer_pkg::*;

  logic       wb_write;
  lc3b_wb_adr wb_adr;
  lc3b_line   wb_wdata;
  logic       wb_resp;
  logic       wb_read;
  lc3b_wb_adr wb_radr;
  lc3b_line   wb_rdata;
  logic       wb_rresp;

  logic       pmem_read;
  logic       pmem_write;
  lc3b_word   pmem_address;
  lc3b_line   pmem_wdata;
  lc3b_line   pmem_rdata;
  logic       pmem_resp;

  modport slave (
    input  wb_write, wb_adr, wb_wdata, wb_read, wb_radr, pmem_rdata, pmem_resp,
    output wb_resp, wb_rdata, wb_rresp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output wb_write, wb_adr, wb_wdata, wb_read, wb_radr, pmem_rdata, pmem_resp,
    input  wb_resp, wb_rdata, wb_rresp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/eviction_write_buffer_control.sv
// rtl/eviction_write_buffer_control.sv - ewb_control: FSM, request priority, strobes and resp pulses
// Purpose: decides each cycle whether to forward a fill, go to memory, capture an eviction or drain.
// Ports: clk/reset; wb_write, wb_read requests; buf_valid, radr_match from the datapath;
//        pmem_resp from memory; wb_resp/wb_rresp pulses, pmem_read/pmem_write strobes;
//        load_buf/clear_buf/load_rdata_fwd/load_rdata_mem datapath enables.
module ewb_control
  import eviction_write_buffer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic wb_write,
  input  logic wb_read,
  input  logic buf_valid,
  input  logic radr_match,
  input  logic pmem_resp,
  output logic wb_resp,
  output logic wb_rresp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_buf,
  output logic clear_buf,
  output logic load_rdata_fwd,
  output logic load_rdata_mem
);

  wb_state state_q, state_d;
  logic    wb_resp_q, wb_resp_d;
  logic    wb_rresp_q, wb_rresp_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wb_resp_q  <= 1'b0;
      wb_rresp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_resp_q  <= wb_resp_d;
      wb_rresp_q <= wb_rresp_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wb_resp_d      = 1'b0;
    wb_rresp_d     = 1'b0;
    load_buf       = 1'b0;
    clear_buf      = 1'b0;
    load_rdata_fwd = 1'b0;
    load_rdata_mem = 1'b0;
    case (state_q)
      IDLE: begin
        // While a response pulse is out, the requester still shows the old
        // request for this one cycle; acting on it would service it twice.
        if (!(wb_resp_q || wb_rresp_q)) begin
          if (wb_read && buf_valid && radr_match) begin
            load_rdata_fwd = 1'b1;
            wb_rresp_d     = 1'b1;
          end else if (wb_read) begin
            state_d = READ;
          end else if (wb_write && !buf_valid) begin
            load_buf  = 1'b1;
            wb_resp_d = 1'b1;
          end else if (buf_valid) begin
            state_d = DRAIN;
          end
        end
      end
      READ: begin
        if (pmem_resp) begin
          load_rdata_mem = 1'b1;
          wb_rresp_d     = 1'b1;
          state_d        = IDLE;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          clear_buf = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_resp    = wb_resp_q;
  assign wb_rresp   = wb_rresp_q;
  assign pmem_read  = (state_q == READ);
  assign pmem_write = (state_q == DRAIN);

endmodule

// File: rtl/eviction_write_buffer.sv
// rtl/eviction_write_buffer.sv - single-entry victim buffer between L1 data cache and memory
// Purpose: holds one evicted dirty line, forwards fills that hit it, drains it when memory is idle.
// Ports: clk, reset (sync, active-high); bus (slave modport) carrying the wb_* cache handshake
//        and the pmem_* memory port.
module eviction_write_buffer
  import eviction_write_buffer_pkg::*;
(
  input logic                           clk,
  input logic                           reset,
  eviction_write_buffer_if.slave        bus
);

  logic       buf_valid_q, buf_valid_d;
  lc3b_wb_adr buf_adr_q, buf_adr_d;
  lc3b_line   buf_data_q, buf_data_d;
  lc3b_line   rdata_q, rdata_d;

  logic radr_match;
  logic load_buf, clear_buf, load_rdata_fwd, load_rdata_mem;
  logic pmem_read, pmem_write;

  ewb_control u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .wb_write       (bus.wb_write),
    .wb_read        (bus.wb_read),
    .buf_valid      (buf_valid_q),
    .radr_match     (radr_match),
    .pmem_resp      (bus.pmem_resp),
    .wb_resp        (bus.wb_resp),
    .wb_rresp       (bus.wb_rresp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .load_buf       (load_buf),
    .clear_buf      (clear_buf),
    .load_rdata_fwd (load_rdata_fwd),
    .load_rdata_mem (load_rdata_mem)
  );

  assign radr_match = (bus.wb_radr == buf_adr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_adr_q   <= '0;
      buf_data_q  <= '0;
      rdata_q     <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_adr_q   <= buf_adr_d;
      buf_data_q  <= buf_data_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_adr_d   = buf_adr_q;
    buf_data_d  = buf_data_q;
    rdata_d     = rdata_q;
    if (load_buf) begin
      buf_valid_d = 1'b1;
      buf_adr_d   = bus.wb_adr;
      buf_data_d  = bus.wb_wdata;
    end
    if (clear_buf) begin
      buf_valid_d = 1'b0;
    end
    if (load_rdata_fwd) begin
      rdata_d = buf_data_q;
    end else if (load_rdata_mem) begin
      rdata_d = bus.pmem_rdata;
    end
  end

  // Address follows the active strobe; zero when the port is idle.
  always_comb begin
    bus.pmem_address = '0;
    if (pmem_read) begin
      bus.pmem_address = line_byte_adr(bus.wb_radr);
    end else if (pmem_write) begin
      bus.pmem_address = line_byte_adr(buf_adr_q);
    end
  end

  assign bus.pmem_read  = pmem_read;
  assign bus.pmem_write = pmem_write;
  assign bus.pmem_wdata = buf_data_q;
  assign bus.wb_rdata   = rdata_q;

endmodule

// File: tb/tb_eviction_write_buffer.sv
// tb/tb_eviction_write_buffer.sv - self-checking bench for eviction_write_buffer
module tb_eviction_write_buffer;
  import eviction_write_buffer_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  eviction_write_buffer_if bus();

  eviction_write_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as seen by physical memory, and the coherent view the
  // cache expects (last accepted eviction per line, else initial memory).
  lc3b_line mem  [4096];
  lc3b_line gold [4096];
  int       mem_lat;
  bit       mem_en;

  localparam lc3b_line D_BEEF = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  // Memory responder: pulses pmem_resp in the mem_lat-th cycle a strobe is held.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      if (mem_en && (bus.pmem_read || bus.pmem_write)) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) mem[bus.pmem_address[15:4]] = bus.pmem_wdata;
          else                bus.pmem_rdata = mem[bus.pmem_address[15:4]];
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic lc3b_line rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic evict(input lc3b_wb_adr a, input lc3b_line d, output int lat);
    bus.wb_adr   = a;
    bus.wb_wdata = d;
    bus.wb_write = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      total++;
      if (bus.pmem_read && bus.pmem_write) begin
        bad++;
        $display("FAIL strobe_excl: pmem_read and pmem_write both high during evict");
      end
    end while (!bus.wb_resp && lat < 300);
    bus.wb_write = 1'b0;
    total++;
    if (!bus.wb_resp) begin
      bad++;
      $display("FAIL evict_timeout: adr=%h no wb_resp after %0d cycles", a, lat);
    end
    gold[a] = d;
  endtask

  task automatic fill(input lc3b_wb_adr a, output lc3b_line d, output int lat,
                      output int rd_cyc, output lc3b_word rd_addr, output bit saw_wr);
    bus.wb_radr = a;
    bus.wb_read = 1'b1;
    lat = 0;
    rd_cyc = -1;
    rd_addr = '0;
    saw_wr = 1'b0;
    do begin
      tick();
      lat++;
      if (bus.pmem_read && rd_cyc < 0) begin
        rd_cyc  = lat;
        rd_addr = bus.pmem_address;
      end
      if (bus.pmem_write) saw_wr = 1'b1;
      total++;
      if (bus.pmem_read && bus.pmem_write) begin
        bad++;
        $display("FAIL strobe_excl: pmem_read and pmem_write both high during fill");
      end
    end while (!bus.wb_rresp && lat < 300);
    bus.wb_read = 1'b0;
    d = bus.wb_rdata;
    total++;
    if (!bus.wb_rresp) begin
      bad++;
      $display("FAIL fill_timeout: adr=%h no wb_rresp after %0d cycles", a, lat);
    end
  endtask

  task automatic wait_quiet(output bit saw_rd);
    int q, n;
    q = 0;
    n = 0;
    saw_rd = 1'b0;
    while (q < 3 && n < 300) begin
      tick();
      n++;
      if (bus.pmem_read) saw_rd = 1'b1;
      if (bus.pmem_read || bus.pmem_write) q = 0;
      else q++;
    end
    total++;
    if (q < 3) begin
      bad++;
      $display("FAIL quiet_timeout: memory port still busy after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({bus.wb_resp, bus.wb_rresp, bus.pmem_read, bus.pmem_write} !== 4'b0000 ||
          bus.wb_rdata !== '0 || bus.pmem_address !== 16'h0000) begin
        bad++;
        $display("FAIL reset_idle: cycle %0d resp=%b rresp=%b rd=%b wr=%b rdata=%h addr=%h, want all 0",
                 i, bus.wb_resp, bus.wb_rresp, bus.pmem_read, bus.pmem_write, bus.wb_rdata, bus.pmem_address);
      end
    end
  endtask

  task automatic test_evict_drain();
    int lat, n;
    mem_lat = 3;
    evict(12'h0A3, D_BEEF, lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL evict_latency: got %0d want 1", lat); end
    tick();
    total++;
    if (bus.pmem_write !== 1'b0) begin bad++; $display("FAIL drain_early: pmem_write=%b want 0", bus.pmem_write); end
    tick();
    total++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_address !== 16'h0A30 || bus.pmem_wdata !== D_BEEF) begin
      bad++;
      $display("FAIL drain_start: wr=%b addr=%h data=%h want 1 0a30 %h",
               bus.pmem_write, bus.pmem_address, bus.pmem_wdata, D_BEEF);
    end
    n = 1;
    while (bus.pmem_write && n < 50) begin
      tick();
      if (bus.pmem_write) n++;
    end
    total++;
    if (n !== 3) begin bad++; $display("FAIL drain_len: pmem_write cycles=%0d want 3", n); end
    total++;
    if (mem[12'h0A3] !== D_BEEF) begin bad++; $display("FAIL drain_data: mem=%h want %h", mem[12'h0A3], D_BEEF); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0) begin
        bad++;
        $display("FAIL drain_clear: cycle %0d wr=%b rd=%b want 0 0", i, bus.pmem_write, bus.pmem_read);
      end
    end
  endtask

  task automatic test_forward();
    int lat, rc; lc3b_line d, dv; lc3b_word ra; bit sw, srd;
    mem_lat = 2;
    dv = rnd_line();
    evict(12'h0A3, dv, lat);
    tick();
    fill(12'h0A3, d, lat, rc, ra, sw);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL fwd_latency: got %0d want 1", lat); end
    total++;
    if (d !== dv) begin bad++; $display("FAIL fwd_data: got %h want %h", d, dv); end
    wait_quiet(srd);
    total++;
    if (rc !== -1 || srd) begin bad++; $display("FAIL fwd_no_pmem_read: pmem_read seen (cycle %0d / after %b) want never", rc, srd); end
  endtask

  task automatic test_read_bypass();
    int lat, rc, n; lc3b_line d, dv; lc3b_word ra; bit sw, srd;
    mem_lat = 2;
    dv = rnd_line();
    evict(12'h0A3, dv, lat);
    tick();
    fill(12'h011, d, lat, rc, ra, sw);
    total++;
    if (rc !== 1 || ra !== 16'h0110 || sw) begin
      bad++;
      $display("FAIL bypass_read: first pmem_read cycle=%0d addr=%h write_before=%b want 1 0110 0", rc, ra, sw);
    end
    total++;
    if (lat !== mem_lat + 1) begin bad++; $display("FAIL bypass_latency: got %0d want %0d", lat, mem_lat + 1); end
    total++;
    if (d !== gold[12'h011]) begin bad++; $display("FAIL bypass_data: got %h want %h", d, gold[12'h011]); end
    n = 0;
    while (!bus.pmem_write && n < 50) begin tick(); n++; end
    total++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_address !== 16'h0A30 || bus.pmem_wdata !== dv) begin
      bad++;
      $display("FAIL bypass_drain: wr=%b addr=%h data=%h want 1 0a30 %h", bus.pmem_write, bus.pmem_address, bus.pmem_wdata, dv);
    end
    wait_quiet(srd);
  endtask

  task automatic test_stall();
    int lat, n, r; bit got, srd; lc3b_line d1, d2;
    mem_lat = 3;
    d1 = rnd_line();
    d2 = rnd_line();
    evict(12'h0A3, d1, lat);
    bus.wb_adr   = 12'h055;
    bus.wb_wdata = d2;
    bus.wb_write = 1'b1;
    r = -1;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      tick();
      n++;
      if (bus.wb_resp) got = 1'b1;
      else if (bus.pmem_write && bus.pmem_address == 16'h0A30) r = n;
    end
    bus.wb_write = 1'b0;
    total++;
    if (!got || r < 0 || n !== r + 2) begin
      bad++;
      $display("FAIL stall_resp: wb_resp at %0d (seen=%b), last drain cycle %0d, want drain+2", n, got, r);
    end
    gold[12'h055] = d2;
    n = 0;
    while (!bus.pmem_write && n < 50) begin tick(); n++; end
    total++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_address !== 16'h0550 || bus.pmem_wdata !== d2) begin
      bad++;
      $display("FAIL stall_drain2: wr=%b addr=%h data=%h want 1 0550 %h", bus.pmem_write, bus.pmem_address, bus.pmem_wdata, d2);
    end
    wait_quiet(srd);
  endtask

  task automatic test_reset_mid_drain();
    int lat, rc, n; lc3b_line old, d; lc3b_word ra; bit sw;
    old = gold[12'h0A3];
    mem_en = 1'b0;
    evict(12'h0A3, rnd_line(), lat);
    n = 0;
    while (!bus.pmem_write && n < 50) begin tick(); n++; end
    reset = 1'b1;
    tick();
    total++;
    if (bus.pmem_write !== 1'b0) begin bad++; $display("FAIL rst_drain_strobe: pmem_write=%b want 0", bus.pmem_write); end
    reset = 1'b0;
    tick();
    mem_en = 1'b1;
    mem_lat = 1;
    gold[12'h0A3] = old;
    fill(12'h0A3, d, lat, rc, ra, sw);
    total++;
    if (rc !== 1 || ra !== 16'h0A30) begin
      bad++;
      $display("FAIL rst_discard: first pmem_read cycle=%0d addr=%h want 1 0a30", rc, ra);
    end
    total++;
    if (d !== old) begin bad++; $display("FAIL rst_read_data: got %h want %h", d, old); end
  endtask

  task automatic test_random();
    int lat, rc; lc3b_line d; lc3b_word ra; bit sw, srd; lc3b_wb_adr a;
    for (int i = 0; i < 120; i++) begin
      mem_lat = $urandom_range(1, 4);
      a = 12'h200 + 12'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        evict(a, rnd_line(), lat);
      end else begin
        fill(a, d, lat, rc, ra, sw);
        total++;
        if (d !== gold[a]) begin bad++; $display("FAIL rand_fill: op %0d adr=%h got %h want %h", i, a, d, gold[a]); end
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    wait_quiet(srd);
    for (int k = 0; k < 8; k++) begin
      a = 12'h200 + 12'(k);
      total++;
      if (mem[a] !== gold[a]) begin bad++; $display("FAIL rand_final_mem: adr=%h got %h want %h", a, mem[a], gold[a]); end
    end
  endtask

  initial begin : main
    total = 0;
    bad = 0;
    mem_lat = 1;
    mem_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      mem[i]  = rnd_line();
      gold[i] = mem[i];
    end
    reset        = 1'b1;
    bus.wb_write = 1'b0;
    bus.wb_read  = 1'b0;
    bus.wb_adr   = '0;
    bus.wb_radr  = '0;
    bus.wb_wdata = '0;
    test_reset();
    test_evict_drain();
    test_forward();
    test_read_bypass();
    test_stall();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
